// File: rtl/mmio_hub_if.sv
// Core-side MMIO bus between the EX/MEM stage and the I/O hub.
interface mmio_hub_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic        bus_sel;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_sel, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_sel, bus_rdata
  );
endinterface

// File: rtl/mmio_hub.sv
// MMIO hub: output register bank, buffered UART TX queue with drain FSM,
// and a PS2 key-event queue that pops on read.
module mmio_hub #(
  parameter int unsigned OUT_CH     = 4,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned TXQ_DEPTH  = 8,
  parameter int unsigned KEYQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_hub_if.slave               bus,
  output logic [OUT_CH*OUT_W-1:0] out_regs,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_we,
  input  logic                    uart_tx_busy,
  input  logic [7:0]              key_code_in,
  input  logic                    key_strobe_in,
  input  logic [31:0]             num_buffer_in,
  input  logic                    num_valid_in
);
  localparam int unsigned TxPw  = $clog2(TXQ_DEPTH);
  localparam int unsigned TxCw  = TxPw + 1;
  localparam int unsigned KeyPw = $clog2(KEYQ_DEPTH);
  localparam int unsigned KeyCw = KeyPw + 1;

  typedef enum logic [1:0] {StIdle, StSend, StHold} drain_state_e;

  logic [3:0] region;
  logic [5:0] word;
  logic       hit_tx_data, hit_tx_stat, hit_key_data, hit_key_stat, hit_out;

  assign region       = bus.bus_addr[31:28];
  assign word         = bus.bus_addr[7:2];
  assign bus.bus_sel  = (region != 4'h0);
  assign hit_tx_data  = (region == 4'h1) && (word == 6'd0);
  assign hit_tx_stat  = (region == 4'h1) && (word == 6'd1);
  assign hit_key_data = (region == 4'h3) && (word == 6'd0);
  assign hit_key_stat = (region == 4'h3) && (word == 6'd1);
  assign hit_out      = (region == 4'h2) && (32'(word) < OUT_CH);

  logic unused_bus;
  assign unused_bus = ^{bus.bus_addr[27:8], bus.bus_addr[1:0], bus.bus_wdata};

  // UART TX queue and drain FSM
  logic [7:0]      txq_mem [TXQ_DEPTH];
  logic [TxPw-1:0] txq_wptr_q, txq_wptr_d, txq_rptr_q, txq_rptr_d;
  logic [TxCw-1:0] txq_cnt_q, txq_cnt_d;
  logic            tx_ovf_q, tx_ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  drain_state_e    state_q, state_d;
  logic            txq_empty, txq_full, tx_push, tx_push_ok, tx_pop;

  assign txq_empty  = (txq_cnt_q == '0);
  assign txq_full   = (txq_cnt_q == TxCw'(TXQ_DEPTH));
  assign tx_push    = bus.bus_we && hit_tx_data;
  assign tx_push_ok = tx_push && (!txq_full || tx_pop);

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!txq_empty && !uart_tx_busy) begin
          state_d   = StSend;
          tx_data_d = txq_mem[txq_rptr_q];
          tx_pop    = 1'b1;
        end
      end
      StSend:  state_d = StHold;
      // HOLD ignores busy to cover the transmitter's busy-rise latency.
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txq_wptr_d = txq_wptr_q + TxPw'(tx_push_ok);
    txq_rptr_d = txq_rptr_q + TxPw'(tx_pop);
    txq_cnt_d  = txq_cnt_q + TxCw'(tx_push_ok) - TxCw'(tx_pop);
    tx_ovf_d   = tx_ovf_q;
    if (bus.bus_we && hit_tx_stat && bus.bus_wdata[3]) tx_ovf_d = 1'b0;
    if (tx_push && txq_full && !tx_pop)                tx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) txq_mem[txq_wptr_q] <= bus.bus_wdata[7:0];
  end

  assign uart_tx_we   = (state_q == StSend);
  assign uart_tx_data = tx_data_q;

  // Key event queue
  logic [7:0]       keyq_mem [KEYQ_DEPTH];
  logic [KeyPw-1:0] keyq_wptr_q, keyq_wptr_d, keyq_rptr_q, keyq_rptr_d;
  logic [KeyCw-1:0] keyq_cnt_q, keyq_cnt_d;
  logic             key_ovf_q, key_ovf_d;
  logic             keyq_empty, keyq_full, key_pop, key_push_ok;

  assign keyq_empty  = (keyq_cnt_q == '0);
  assign keyq_full   = (keyq_cnt_q == KeyCw'(KEYQ_DEPTH));
  assign key_pop     = bus.bus_re && hit_key_data && !keyq_empty;
  assign key_push_ok = key_strobe_in && (!keyq_full || key_pop);

  always_comb begin
    keyq_wptr_d = keyq_wptr_q + KeyPw'(key_push_ok);
    keyq_rptr_d = keyq_rptr_q + KeyPw'(key_pop);
    keyq_cnt_d  = keyq_cnt_q + KeyCw'(key_push_ok) - KeyCw'(key_pop);
    key_ovf_d   = key_ovf_q;
    if (bus.bus_we && hit_key_stat && bus.bus_wdata[1]) key_ovf_d = 1'b0;
    // A dropped key in the same cycle as a clear still leaves the flag set.
    if (key_strobe_in && keyq_full && !key_pop)          key_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (key_push_ok) keyq_mem[keyq_wptr_q] <= key_code_in;
  end

  // Output register bank
  logic [OUT_CH*OUT_W-1:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (bus.bus_we && hit_out) begin
      for (int unsigned k = 0; k < OUT_CH; k++) begin
        if (word == 6'(k)) out_d[k*OUT_W +: OUT_W] = bus.bus_wdata[OUT_W-1:0];
      end
    end
  end

  assign out_regs = out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tx_data_q   <= '0;
      txq_wptr_q  <= '0;
      txq_rptr_q  <= '0;
      txq_cnt_q   <= '0;
      tx_ovf_q    <= 1'b0;
      keyq_wptr_q <= '0;
      keyq_rptr_q <= '0;
      keyq_cnt_q  <= '0;
      key_ovf_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      txq_wptr_q  <= txq_wptr_d;
      txq_rptr_q  <= txq_rptr_d;
      txq_cnt_q   <= txq_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      keyq_wptr_q <= keyq_wptr_d;
      keyq_rptr_q <= keyq_rptr_d;
      keyq_cnt_q  <= keyq_cnt_d;
      key_ovf_q   <= key_ovf_d;
      out_q       <= out_d;
    end
  end

  // Read mux is purely address-driven; side effects need bus_re/bus_we.
  always_comb begin
    bus.bus_rdata = '0;
    case (region)
      4'h1: begin
        if (word == 6'd1) begin
          bus.bus_rdata = {16'h0, 8'(txq_cnt_q), 4'h0, tx_ovf_q,
                           uart_tx_busy || (state_q != StIdle), txq_full, txq_empty};
        end
      end
      4'h2: begin
        for (int unsigned k = 0; k < OUT_CH; k++) begin
          if (word == 6'(k)) bus.bus_rdata = 32'(out_q[k*OUT_W +: OUT_W]);
        end
      end
      4'h3: begin
        if (word == 6'd0 && !keyq_empty) bus.bus_rdata = {24'h0, keyq_mem[keyq_rptr_q]};
        if (word == 6'd1) bus.bus_rdata = {24'h0, 4'(keyq_cnt_q), 2'b0, key_ovf_q, !keyq_empty};
      end
      4'h5: begin
        if (word == 6'd0) bus.bus_rdata = num_buffer_in;
        if (word == 6'd1) bus.bus_rdata = {31'h0, num_valid_in};
      end
      default: ;
    endcase
  end
endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub for the 5-stage RISC-V core, attached at the EX/MEM stage alongside the BRAM data port. It decodes the non-BRAM address space and provides a configurable bank of output registers (LED/VGA and similar), a buffered UART transmit queue with its own drain state machine, and a PS2 key-event queue with pop-on-read. It replaces the hard-wired single-register MMIO logic: byte-by-byte UART polling is no longer required, and key presses are no longer lost between polls.

## Interface
- OUT_CH, 4: number of output registers (1..16).
- OUT_W, 16: width of each output register (1..32).
- TXQ_DEPTH, 8: UART TX queue depth; power of two, ≥2.
- KEYQ_DEPTH, 4: key queue depth; power of two, ≥2.
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- bus_addr  in  32  EX/MEM ALU result (byte address).
- bus_wdata  in  32  EX/MEM store data.
- bus_we  in  1  store strobe, one cycle per sw.
- bus_re  in  1  load strobe, one cycle per lw.
- bus_sel  out  1  high when bus_addr[31:28] != 0. The core masks BRAM writes with this signal and selects bus_rdata.
- bus_rdata  out  32  read data, combinational from bus_addr.
- out_regs  out  OUT_CH*OUT_W  output registers; channel k occupies bits [k*OUT_W +: OUT_W].
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_tx_we  out  1  one-cycle send pulse.
- uart_tx_busy  in  1  transmitter busy.
- key_code_in  in  8  PS2 ASCII/scancode.
- key_strobe_in  in  1  one-cycle pulse per new key.
- num_buffer_in  in  32  number input buffer.
- num_valid_in  in  1  number valid flag.

## Operation
- Decoding uses bus_addr[31:28] for the region and bus_addr[7:2] for the word. Any unmapped word reads 0, and writes to it are ignored.
- 0x1000_0000 (UART data):
  - Write pushes bus_wdata[7:0] to the TX queue.
  - Read returns 0.
- 0x1000_0004 (UART status): read returns {16'b0, txq_count[7:0], 4'b0, tx_ovf, busy_any, txq_full, txq_empty}.
  - busy_any = uart_tx_busy | (drain FSM not in IDLE).
  - Writing bit3 = 1 clears tx_ovf.
- 0x2000_0000 + 4k, k < OUT_CH (output register k):
  - Write loads bus_wdata[OUT_W-1:0].
  - Read returns the register zero-extended.
  - k ≥ OUT_CH is unmapped.
- 0x3000_0000 (key data): read returns {24'b0, head} and pops the key queue. Reading an empty queue returns 0 and does not pop.
- 0x3000_0004 (key status): read returns {24'b0, keyq_count[3:0], 2'b0, key_ovf, ~keyq_empty}. Writing bit1 = 1 clears key_ovf.
- 0x5000_0000 reads num_buffer_in. 0x5000_0004 reads {31'b0, num_valid_in}.
- Pops and status clears take effect only when bus_re/bus_we is asserted. Address alone has no side effect.
- TX queue boundaries:
  - Push while full with no same-cycle drain pop: byte dropped, tx_ovf set (sticky).
  - Push while full with a same-cycle pop: push accepted, count unchanged.
  - Push and pop on a non-full queue: count unchanged.
- Key queue boundaries:
  - key_strobe_in while full with no same-cycle pop: code dropped, key_ovf set.
  - Strobe and pop in the same cycle: both take effect.
- Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Drain FSM (IDLE, SEND, HOLD):
  - IDLE → SEND when the queue is non-empty and uart_tx_busy = 0. On this transition, uart_tx_data is loaded from head and the queue pops.
  - SEND: uart_tx_we = 1 for exactly this cycle, then → HOLD.
  - HOLD: lasts one cycle and ignores busy, which covers the transmitter's busy-rise latency. Then → IDLE.
  - Maximum issue rate is one byte per 3 cycles when the transmitter is never busy.

## Timing
- All outputs reset to 0. This covers out_regs, uart_tx_data, uart_tx_we, both queues (empty), both overflow flags, and the FSM (IDLE).
- Reset asserted mid-transfer aborts immediately: uart_tx_we drops asynchronously and queued bytes are discarded.
- bus_rdata and bus_sel are combinational in the same cycle. A pop read returns the pre-pop head; the pointer updates at the next rising edge.
- A write to an output register is visible on out_regs one cycle after the bus_we cycle.
- TX latency: sw to an idle, empty queue with busy = 0 gives uart_tx_we high 2 cycles after the bus_we cycle (push edge, then IDLE→SEND edge).
- Key latency: a key strobe at edge N is readable (status bit0 = 1) from cycle N+1.

## Test plan
- Reset, then read 0x1000_0004 → 0x0000_0001. Read 0x3000_0004 → 0. out_regs = 0.
- Write 0x00AB to 0x2000_0008 with OUT_CH = 4 → channel 2 = 0x00AB on the next cycle and reads back 0x0000_00AB. A write to 0x2000_0010 changes nothing and reads 0.
- Hold busy = 1 and push 9 bytes 0x41..0x49 (TXQ_DEPTH = 8) → count = 8, full = 1, tx_ovf = 1. Release busy → 0x41..0x48 each emitted with a single-cycle uart_tx_we, gaps ≥ 3 cycles, 0x49 never sent.
- Strobe keys 0x31, 0x32, 0x33 → three reads of 0x3000_0000 return 0x31, 0x32, 0x33, then 0. A strobe on the same cycle as a pop of a full queue → no key_ovf, count unchanged.
- Push 3 bytes, assert rst low during SEND → uart_tx_we falls with no clock edge. After release, queue is empty and no further pulses occur.
- Read 0x5000_0000 / 0x5000_0004 with num_buffer_in = 0x1234 and num_valid_in = 1 → 0x0000_1234 / 0x0000_0001, and bus_sel = 1. Address 0x0000_0100 → bus_sel = 0.
